// File: rtl/light_timer_if.sv
// Handshake between the light FSM and its seconds timer.
// The FSM (master) drives the restart request, and the timer (slave) returns the timeout levels, the tick and the seconds count.
interface light_timer_if;
   logic       sc;
   logic       t_3;
   logic       t_30;
   logic       tick;
   logic [7:0] sec;

   modport master (output sc, input t_3, t_30, tick, sec);
   modport slave  (input sc, output t_3, t_30, tick, sec);
endinterface

// File: rtl/light_timer.sv
// Seconds timer for the traffic-light FSM: prescaler, saturating elapsed count, short/long timeouts.
// Optional macro LIGHT_TIMER_BCD_EN switches the sec output from binary to two BCD digits.
module light_timer #(
   parameter int CLK_DIV = 50000000,
   parameter int SHORT_S = 3,
   parameter int LONG_S  = 30
) (
   input  logic         clk,
   input  logic         rst,
   light_timer_if.slave bus
);

   localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);
   localparam logic [6:0]    SHORT_E  = 7'(SHORT_S);
   localparam logic [6:0]    LONG_E   = 7'(LONG_S);

   logic [PW-1:0] presc;
   logic [6:0]    elapsed;
   logic [6:0]    elapsed_nxt;
   logic          sec_due;
   logic          sec_step;
   logic          tick_q;
   logic          t3_q;
   logic          t30_q;

   always_comb begin
      sec_due     = (presc == PRE_LAST);
      sec_step    = (elapsed < LONG_E);
      elapsed_nxt = sec_step ? elapsed + 7'd1 : elapsed;
   end

   // sc outranks a second boundary falling on the same edge
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         presc   <= '0;
         elapsed <= '0;
         tick_q  <= 1'b0;
         t3_q    <= 1'b0;
         t30_q   <= 1'b0;
      end else if (bus.sc) begin
         presc   <= '0;
         elapsed <= '0;
         tick_q  <= 1'b0;
         t3_q    <= 1'b0;
         t30_q   <= 1'b0;
      end else if (sec_due) begin
         presc   <= '0;
         tick_q  <= 1'b1;
         elapsed <= elapsed_nxt;
         t3_q    <= (elapsed_nxt >= SHORT_E);
         t30_q   <= (elapsed_nxt >= LONG_E);
      end else begin
         presc   <= presc + PW'(1);
         tick_q  <= 1'b0;
      end
   end

   assign bus.tick = tick_q;
   assign bus.t_3  = t3_q;
   assign bus.t_30 = t30_q;

`ifdef LIGHT_TIMER_BCD_EN
   logic [3:0] tens;
   logic [3:0] units;

   // digits track elapsed incrementally so no divider is needed
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tens  <= '0;
         units <= '0;
      end else if (bus.sc) begin
         tens  <= '0;
         units <= '0;
      end else if (sec_due && sec_step) begin
         if (units == 4'd9) begin
            units <= '0;
            tens  <= tens + 4'd1;
         end else begin
            units <= units + 4'd1;
         end
      end
   end

   assign bus.sec = {tens, units};
`else
   assign bus.sec = {1'b0, elapsed};
`endif

endmodule
